// File: rtl/reorder_pkg.sv
// Shared types and defaults for the streaming reorder buffer.
// Holds the FSM state encoding and an index-width helper.
package reorder_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 9;
    localparam int IDX_W_DEF  = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_slot_ram.sv
// DEPTH x DATA_W slot flops plus a written bitmap.
// One write port, one combinational read port, synchronous clear.
module reorder_slot_ram
    import reorder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_written,
    output logic              wr_seen
);

    logic [DATA_W-1:0] slot [DEPTH];
    logic [DEPTH-1:0]  written;

    // Slot contents are qualified by the bitmap, so they need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && wr_idx == IDX_W'(i)) begin
                slot[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written <= '0;
        end else if (clr) begin
            written <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && wr_idx == IDX_W'(i)) begin
                    written[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_data    = '0;
        rd_written = 1'b0;
        wr_seen    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data    = slot[i];
                rd_written = written[i];
            end
            if (wr_idx == IDX_W'(i)) begin
                wr_seen = written[i];
            end
        end
    end

endmodule

// File: rtl/reorder_buffer_seq.sv
// Streaming reorder buffer: scatter one frame by index,
// then drain slots 0..DEPTH-1 in order with hole/error reporting.
module reorder_buffer_seq
    import reorder_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                DEPTH    = DEPTH_DEF,
    parameter int                IDX_W    = IDX_W_DEF,
    parameter logic [DATA_W-1:0] FILL_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_index,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_hole,
    output logic              out_last,
    output logic              err_dup,
    output logic              err_range,
    output logic              frame_done
);

    if (DEPTH < 2 || IDX_W < clog2(DEPTH)) begin : g_bad_cfg
        $error("reorder_buffer_seq: IDX_W too small or DEPTH < 2");
    end

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  wr_cnt;
    logic [IDX_W-1:0]  rd_ptr;
    logic              in_fill;
    logic              in_drain;
    logic              in_acc;
    logic              out_acc;
    logic              in_range;
    logic              in_end;
    logic              out_end;
    logic              dup_hit;
    logic              rd_written;
    logic [DATA_W-1:0] rd_data;

    assign in_fill  = (state == ST_FILL);
    assign in_drain = (state == ST_DRAIN);
    assign in_acc   = in_valid & in_fill;
    assign out_acc  = out_ready & in_drain;
    assign in_range = 32'(in_index) < 32'(DEPTH);
    assign in_end   = in_acc & (in_last | (wr_cnt == LAST));
    assign out_end  = out_acc & (rd_ptr == LAST);

    reorder_slot_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk        (clk),
        .rst        (rst),
        .clr        (out_end),
        .wr_en      (in_acc & in_range),
        .wr_idx     (in_index),
        .wr_data    (in_data),
        .rd_idx     (rd_ptr),
        .rd_data    (rd_data),
        .rd_written (rd_written),
        .wr_seen    (dup_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_FILL:  if (in_end)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (out_end) state_nxt = ST_FILL;
        endcase
    end

    always_comb begin
        in_ready   = in_fill;
        out_valid  = in_drain;
        out_index  = rd_ptr;
        out_hole   = ~rd_written;
        out_data   = rd_written ? rd_data : FILL_VAL;
        out_last   = (rd_ptr == LAST);
        frame_done = out_end;
    end

    // Counters and sticky flags all return to zero on the last drain beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt    <= '0;
            rd_ptr    <= '0;
            err_dup   <= 1'b0;
            err_range <= 1'b0;
        end else if (out_end) begin
            wr_cnt    <= '0;
            rd_ptr    <= '0;
            err_dup   <= 1'b0;
            err_range <= 1'b0;
        end else begin
            if (in_acc) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (!in_range) begin
                    err_range <= 1'b1;
                end else if (dup_hit) begin
                    err_dup <= 1'b1;
                end
            end
            if (out_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer_seq.sv
// Bench for reorder_buffer_seq: directed frame table,
// mid-drain reset, and random frames against a slot model.
module tb_reorder_buffer_seq;

    localparam int DW = 8;
    localparam int DP = 9;
    localparam int IW = 4;

    typedef struct packed {
        logic [3:0]          n;
        logic [8:0][7:0]     d;
        logic [8:0][3:0]     ix;
        logic [8:0][7:0]     exp;
        logic [8:0]          hole;
        logic                dup;
        logic                rng;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [IW-1:0] in_index;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_index;
    logic          out_hole;
    logic          out_last;
    logic          err_dup;
    logic          err_range;
    logic          frame_done;

    int vectors = 0;
    int miscompares = 0;

    frame_t tab [4];

    always #5 clk = ~clk;

    reorder_buffer_seq #(
        .DATA_W   (DW),
        .DEPTH    (DP),
        .IDX_W    (IW),
        .FILL_VAL (8'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_index   (in_index),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_hole   (out_hole),
        .out_last   (out_last),
        .err_dup    (err_dup),
        .err_range  (err_range),
        .frame_done (frame_done)
    );

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference: replay the beats into an array of slots in arrival order.
    task automatic model(inout frame_t f);
        int k;
        f.exp  = '0;
        f.hole = '1;
        f.dup  = 1'b0;
        f.rng  = 1'b0;
        for (int b = 0; b < int'(f.n); b++) begin
            k = int'(f.ix[b]);
            if (k < DP) begin
                if (!f.hole[k]) f.dup = 1'b1;
                f.exp[k]  = f.d[b];
                f.hole[k] = 1'b0;
            end else begin
                f.rng = 1'b1;
            end
        end
    endtask

    task automatic run_frame(input frame_t f, input int gap,
                             input int rdy, input int abort_at);
        int s;
        int cyc;
        for (int b = 0; b < int'(f.n); b++) begin
            while ($urandom_range(99) < gap) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = f.d[b];
            in_index = f.ix[b];
            in_last  = (b == int'(f.n) - 1) &&
                       (int'(f.n) < DP || $urandom_range(1) == 1);
            #1;
            chk("fill_in_ready", int'(in_ready), 1);
            chk("fill_out_valid", int'(out_valid), 0);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        chk("latency_out_valid", int'(out_valid), 1);
        chk("drain_in_ready", int'(in_ready), 0);
        s   = 0;
        cyc = 0;
        while (s < DP && cyc < 2000) begin
            if (s == abort_at) begin
                out_ready = 1'b0;
                rst = 1'b1;
                #1;
                chk("abort_out_valid", int'(out_valid), 0);
                chk("abort_in_ready", int'(in_ready), 1);
                chk("abort_frame_done", int'(frame_done), 0);
                chk("abort_err_dup", int'(err_dup), 0);
                chk("abort_out_index", int'(out_index), 0);
                @(negedge clk);
                rst = 1'b0;
                #1;
                return;
            end
            out_ready = ($urandom_range(99) < rdy);
            #1;
            if (!out_valid) begin
                chk("drain_out_valid", 0, 1);
                break;
            end
            chk("out_index", int'(out_index), s);
            chk("out_data", int'(out_data), int'(f.exp[s]));
            chk("out_hole", int'(out_hole), int'(f.hole[s]));
            chk("out_last", int'(out_last), int'(s == DP - 1));
            chk("err_dup", int'(err_dup), int'(f.dup));
            chk("err_range", int'(err_range), int'(f.rng));
            chk("frame_done", int'(frame_done),
                int'(out_ready && s == DP - 1));
            @(posedge clk);
            if (out_ready) s++;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        if (s < DP) chk("drain_slots", s, DP);
        #1;
        chk("post_in_ready", int'(in_ready), 1);
        chk("post_out_valid", int'(out_valid), 0);
        chk("post_err_dup", int'(err_dup), 0);
        chk("post_err_range", int'(err_range), 0);
    endtask

    initial begin
        frame_t f;

        // Packed arrays list element [8] first, element [0] last.
        tab[0].n    = 4'd9;
        tab[0].d    = {8'd26, 8'd24, 8'd22, 8'd20, 8'd18,
                       8'd10, 8'd8, 8'd6, 8'd2};
        tab[0].ix   = {4'd8, 4'd6, 4'd5, 4'd4, 4'd3,
                       4'd0, 4'd2, 4'd0, 4'd1};
        tab[0].exp  = {8'd26, 8'd0, 8'd24, 8'd22, 8'd20,
                       8'd18, 8'd8, 8'd2, 8'd10};
        tab[0].hole = 9'b010000000;
        tab[0].dup  = 1'b1;
        tab[0].rng  = 1'b0;

        tab[1].n    = 4'd9;
        tab[1].d    = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5,
                       8'd4, 8'd3, 8'd2, 8'd1};
        tab[1].ix   = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                       4'd5, 4'd6, 4'd7, 4'd8};
        tab[1].exp  = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5,
                       8'd6, 8'd7, 8'd8, 8'd9};
        tab[1].hole = 9'b000000000;
        tab[1].dup  = 1'b0;
        tab[1].rng  = 1'b0;

        tab[2].n    = 4'd3;
        tab[2].d    = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                       8'd0, 8'd7, 8'd6, 8'd5};
        tab[2].ix   = {4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                       4'd0, 4'd7, 4'd0, 4'd4};
        tab[2].exp  = {8'd0, 8'd7, 8'd0, 8'd0, 8'd5,
                       8'd0, 8'd0, 8'd0, 8'd6};
        tab[2].hole = 9'b101101110;
        tab[2].dup  = 1'b0;
        tab[2].rng  = 1'b0;

        tab[3].n    = 4'd9;
        tab[3].d    = {8'd19, 8'd18, 8'd17, 8'd16, 8'd15,
                       8'd14, 8'd13, 8'd12, 8'd11};
        tab[3].ix   = {4'd8, 4'd7, 4'd6, 4'd5, 4'd4,
                       4'd12, 4'd2, 4'd1, 4'd0};
        tab[3].exp  = {8'd19, 8'd18, 8'd17, 8'd16, 8'd15,
                       8'd0, 8'd13, 8'd12, 8'd11};
        tab[3].hole = 9'b000001000;
        tab[3].dup  = 1'b0;
        tab[3].rng  = 1'b1;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_index  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_err_dup", int'(err_dup), 0);
        chk("rst_err_range", int'(err_range), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        for (int t = 0; t < 4; t++) begin
            run_frame(tab[t], 0, 100, -1);
        end

        // Abort a dup frame at rd_ptr=4, then a holey frame must drain clean.
        run_frame(tab[0], 0, 100, 4);
        run_frame(tab[2], 0, 100, -1);

        for (int t = 0; t < 4; t++) begin
            run_frame(tab[t], 40, 50, -1);
        end

        for (int r = 0; r < 20; r++) begin
            f   = '0;
            f.n = 4'($urandom_range(DP, 1));
            for (int b = 0; b < DP; b++) begin
                f.d[b]  = 8'($urandom_range(255));
                f.ix[b] = ($urandom_range(9) == 0) ?
                          4'($urandom_range(15, 9)) :
                          4'($urandom_range(8));
            end
            model(f);
            run_frame(f, 30, 50, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
